// File: rtl/op_mux_pkg.sv
// Shared types and constants for the operand source multiplexer.
package op_mux_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  // Source 0 is manual/external control, source 1 is internal ROM execution.
  localparam int unsigned MODE_MANUAL = 0;
  localparam int unsigned MODE_ROM    = 1;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_OP_W   = 3;

endpackage

// File: rtl/op_source_mux_if.sv
// Source-side and output-side valid/ready bundle of the operand source mux.
interface op_source_mux_if
  import op_mux_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned OP_W    = DEF_OP_W,
  parameter int unsigned NUM_SRC = 2,
  localparam int unsigned SEL_W  = $clog2(NUM_SRC)
);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*DATA_W-1:0] src_a;
  logic [NUM_SRC*DATA_W-1:0] src_b;
  logic [NUM_SRC*OP_W-1:0]   src_opcode;

  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_a;
  logic [DATA_W-1:0]         out_b;
  logic [OP_W-1:0]           out_opcode;
  logic [SEL_W-1:0]          out_src;

  modport master (
    output src_valid, src_a, src_b, src_opcode, out_ready,
    input  src_ready, out_valid, out_a, out_b, out_opcode, out_src
  );

  modport slave (
    input  src_valid, src_a, src_b, src_opcode, out_ready,
    output src_ready, out_valid, out_a, out_b, out_opcode, out_src
  );

endinterface

// File: rtl/op_out_reg.sv
// One-entry valid/ready pipeline register; accepts a new word in the same
// cycle the held one is taken downstream.
module op_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Data is left untouched when the word drains without a replacement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/op_source_mux.sv
// Selects one of NUM_SRC operand sources into a one-entry output register;
// mode changes drain the held word before retargeting.
module op_source_mux
  import op_mux_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned OP_W    = DEF_OP_W,
  parameter int unsigned NUM_SRC = 2,
  localparam int unsigned SEL_W  = $clog2(NUM_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] mode_req,
  op_source_mux_if.slave   bus,
  output logic [SEL_W-1:0] mode_cur,
  output logic             switch_busy
);

  localparam int unsigned PAY_W = SEL_W + OP_W + 2 * DATA_W;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] mode_q, mode_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;

  logic              free;
  logic              sel_valid;
  logic              in_valid;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic              req_legal;
  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;
  logic              reg_valid;

  always_comb begin
    sel_valid = 1'b0;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (SEL_W'(i) == mode_q) begin
        sel_valid = bus.src_valid[i];
        sel_a     = bus.src_a[i*DATA_W +: DATA_W];
        sel_b     = bus.src_b[i*DATA_W +: DATA_W];
        sel_op    = bus.src_opcode[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    bus.src_ready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      bus.src_ready[i] = (state_q == ST_RUN) && (SEL_W'(i) == mode_q) && free;
    end
  end

  assign in_valid = (state_q == ST_RUN) && sel_valid;
  assign pay_in   = {mode_q, sel_op, sel_b, sel_a};

  op_out_reg #(
    .W (PAY_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (free),
    .in_data   (pay_in),
    .out_valid (reg_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_out)
  );

  assign bus.out_valid = reg_valid;
  assign {bus.out_src, bus.out_opcode, bus.out_b, bus.out_a} = pay_out;

  assign req_legal = 32'(mode_req) < NUM_SRC;

  // A transfer in the cycle the request is seen still completes; DRAIN then
  // waits until that word (or any older one) has left the register.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      ST_RUN: begin
        if ((mode_req != mode_q) && req_legal) begin
          tgt_d   = mode_req;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (free) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        mode_d  = tgt_q;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      mode_q  <= SEL_W'(MODE_MANUAL);
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
    end
  end

  assign mode_cur    = mode_q;
  assign switch_busy = (state_q != ST_RUN);

endmodule

// File: tb/tb_op_source_mux.sv
// Bench for op_source_mux with three sources: vector table, hand sequences
// for switch/reset corners, then randomized traffic against a queue model.
module tb_op_source_mux;

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 3;
  localparam int unsigned NS = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode_req;
  logic [1:0] mode_cur;
  logic       switch_busy;

  op_source_mux_if #(.DATA_W(DW), .OP_W(OW), .NUM_SRC(NS)) bus ();

  op_source_mux #(.DATA_W(DW), .OP_W(OW), .NUM_SRC(NS)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_req    (mode_req),
    .bus         (bus),
    .mode_cur    (mode_cur),
    .switch_busy (switch_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] va [3];
  logic [7:0] vb [3];
  logic [2:0] vo [3];

  typedef struct {
    logic [1:0] mreq; logic [2:0] sv; logic ordy;
    logic [7:0] a0, b0; logic [2:0] o0;
    logic [7:0] a1, b1; logic [2:0] o1;
    logic [2:0] srdy; logic ov; logic [7:0] oa, ob; logic [2:0] oo;
    logic [1:0] osrc, mcur; logic busy;
  } vec_t;

  typedef struct { logic [7:0] a, b; logic [2:0] op; logic [1:0] src; } word_t;

  vec_t vt [23];

  function automatic vec_t mk(
      input logic [1:0] mreq, input logic [2:0] sv, input logic ordy,
      input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] o0,
      input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] o1,
      input logic [2:0] srdy, input logic ov, input logic [7:0] oa,
      input logic [7:0] ob, input logic [2:0] oo, input logic [1:0] osrc,
      input logic [1:0] mcur, input logic busy);
    vec_t v;
    v.mreq = mreq; v.sv = sv; v.ordy = ordy;
    v.a0 = a0; v.b0 = b0; v.o0 = o0; v.a1 = a1; v.b1 = b1; v.o1 = o1;
    v.srdy = srdy; v.ov = ov; v.oa = oa; v.ob = ob; v.oo = oo;
    v.osrc = osrc; v.mcur = mcur; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pack();
    bus.src_a      = {va[2], va[1], va[0]};
    bus.src_b      = {vb[2], vb[1], vb[0]};
    bus.src_opcode = {vo[2], vo[1], vo[0]};
  endtask

  task automatic drive(input logic [1:0] mreq, input logic [2:0] sv, input logic ordy);
    mode_req      = mreq;
    bus.src_valid = sv;
    bus.out_ready = ordy;
    pack();
  endtask

  // Reference model: queue of accepted words plus switch bookkeeping.
  int    m_phase;
  int    m_mode, m_tgt;
  word_t q[$];
  word_t m_last;

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_tgt = 0;
    q.delete();
    m_last = '{a: 8'h00, b: 8'h00, op: 3'd0, src: 2'd0};
  endtask

  function automatic logic [2:0] model_rdy();
    bit fr = (q.size() == 0) || bus.out_ready;
    return (m_phase == 0 && fr) ? 3'(1 << m_mode) : 3'b000;
  endfunction

  task automatic model_check(input string tag);
    chk({tag, " src_ready"}, 32'(bus.src_ready), 32'(model_rdy()));
    chk({tag, " busy"}, 32'(switch_busy), 32'(m_phase != 0));
    chk({tag, " mode_cur"}, 32'(mode_cur), 32'(m_mode));
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, " out_word"}, {9'd0, bus.out_src, bus.out_opcode, bus.out_b, bus.out_a},
        {9'd0, m_last.src, m_last.op, m_last.b, m_last.a});
  endtask

  task automatic model_edge();
    logic [2:0] rdy = model_rdy();
    bit empty_now = (q.size() == 0) || bus.out_ready;
    if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
    if ((rdy & bus.src_valid) != 3'b000) begin
      m_last = '{a: va[m_mode], b: vb[m_mode], op: vo[m_mode], src: 2'(m_mode)};
      q.push_back(m_last);
    end
    case (m_phase)
      0: if (int'(mode_req) != m_mode && int'(mode_req) < int'(NS)) begin
           m_tgt = int'(mode_req); m_phase = 1;
         end
      1: if (empty_now) m_phase = 2;
      default: begin m_mode = m_tgt; m_phase = 0; end
    endcase
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin va[i] = '0; vb[i] = '0; vo[i] = '0; end
    reset = 1'b1;
    drive(2'd0, 3'b000, 1'b1);

    //        mreq sv      rdy a0     b0     o0 a1     b1     o1 | srdy    ov oa     ob     oo osrc mcur busy
    vt[0]  = mk(0, 3'b000, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 3'b001, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[1]  = mk(0, 3'b001, 1, 8'h12, 8'h34, 3, 8'h00, 8'h00, 0, 3'b001, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vt[2]  = mk(0, 3'b001, 1, 8'h01, 8'h11, 1, 8'h00, 8'h00, 0, 3'b001, 1, 8'h12, 8'h34, 3, 0, 0, 0);
    vt[3]  = mk(0, 3'b001, 1, 8'h02, 8'h22, 2, 8'h00, 8'h00, 0, 3'b001, 1, 8'h01, 8'h11, 1, 0, 0, 0);
    vt[4]  = mk(0, 3'b001, 1, 8'h03, 8'h33, 4, 8'h00, 8'h00, 0, 3'b001, 1, 8'h02, 8'h22, 2, 0, 0, 0);
    vt[5]  = mk(0, 3'b001, 1, 8'h04, 8'h44, 5, 8'h00, 8'h00, 0, 3'b001, 1, 8'h03, 8'h33, 4, 0, 0, 0);
    vt[6]  = mk(0, 3'b001, 0, 8'h05, 8'h55, 6, 8'h00, 8'h00, 0, 3'b000, 1, 8'h04, 8'h44, 5, 0, 0, 0);
    vt[7]  = mk(0, 3'b001, 0, 8'h05, 8'h55, 6, 8'h00, 8'h00, 0, 3'b000, 1, 8'h04, 8'h44, 5, 0, 0, 0);
    vt[8]  = mk(0, 3'b001, 1, 8'h05, 8'h55, 6, 8'h00, 8'h00, 0, 3'b001, 1, 8'h04, 8'h44, 5, 0, 0, 0);
    vt[9]  = mk(0, 3'b000, 0, 8'h05, 8'h55, 6, 8'h00, 8'h00, 0, 3'b000, 1, 8'h05, 8'h55, 6, 0, 0, 0);
    vt[10] = mk(1, 3'b010, 0, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b000, 1, 8'h05, 8'h55, 6, 0, 0, 0);
    vt[11] = mk(1, 3'b010, 0, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b000, 1, 8'h05, 8'h55, 6, 0, 0, 1);
    vt[12] = mk(2, 3'b010, 0, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b000, 1, 8'h05, 8'h55, 6, 0, 0, 1);
    vt[13] = mk(2, 3'b010, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b000, 1, 8'h05, 8'h55, 6, 0, 0, 1);
    vt[14] = mk(1, 3'b010, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b000, 0, 8'h05, 8'h55, 6, 0, 0, 1);
    vt[15] = mk(1, 3'b010, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b010, 0, 8'h05, 8'h55, 6, 0, 1, 0);
    vt[16] = mk(1, 3'b000, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b010, 1, 8'hAA, 8'hBB, 7, 1, 1, 0);
    vt[17] = mk(3, 3'b000, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b010, 0, 8'hAA, 8'hBB, 7, 1, 1, 0);
    vt[18] = mk(3, 3'b000, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b010, 0, 8'hAA, 8'hBB, 7, 1, 1, 0);
    vt[19] = mk(0, 3'b000, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b010, 0, 8'hAA, 8'hBB, 7, 1, 1, 0);
    vt[20] = mk(0, 3'b000, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b000, 0, 8'hAA, 8'hBB, 7, 1, 1, 1);
    vt[21] = mk(0, 3'b000, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b000, 0, 8'hAA, 8'hBB, 7, 1, 1, 1);
    vt[22] = mk(0, 3'b000, 1, 8'h05, 8'h55, 6, 8'hAA, 8'hBB, 7, 3'b001, 0, 8'hAA, 8'hBB, 7, 1, 0, 0);

    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < 23; r++) begin
      va[0] = vt[r].a0; vb[0] = vt[r].b0; vo[0] = vt[r].o0;
      va[1] = vt[r].a1; vb[1] = vt[r].b1; vo[1] = vt[r].o1;
      drive(vt[r].mreq, vt[r].sv, vt[r].ordy);
      #1;
      chk($sformatf("row%0d src_ready", r), 32'(bus.src_ready), 32'(vt[r].srdy));
      chk($sformatf("row%0d out_valid", r), 32'(bus.out_valid), 32'(vt[r].ov));
      chk($sformatf("row%0d out_a", r), 32'(bus.out_a), 32'(vt[r].oa));
      chk($sformatf("row%0d out_b", r), 32'(bus.out_b), 32'(vt[r].ob));
      chk($sformatf("row%0d out_opcode", r), 32'(bus.out_opcode), 32'(vt[r].oo));
      chk($sformatf("row%0d out_src", r), 32'(bus.out_src), 32'(vt[r].osrc));
      chk($sformatf("row%0d mode_cur", r), 32'(mode_cur), 32'(vt[r].mcur));
      chk($sformatf("row%0d switch_busy", r), 32'(switch_busy), 32'(vt[r].busy));
      @(negedge clk);
    end

    // Switch to source 2, hold a word, start a switch, reset mid-DRAIN.
    drive(2'd2, 3'b000, 1'b1); #1; chk("hs A busy", 32'(switch_busy), 32'd0); @(negedge clk);
    #1; chk("hs B busy", 32'(switch_busy), 32'd1); @(negedge clk);
    #1; chk("hs C busy", 32'(switch_busy), 32'd1); chk("hs C mode", 32'(mode_cur), 32'd0);
    @(negedge clk);
    va[2] = 8'h77; vb[2] = 8'h66; vo[2] = 3'd5;
    drive(2'd2, 3'b100, 1'b0); #1;
    chk("hs D mode", 32'(mode_cur), 32'd2);
    chk("hs D busy", 32'(switch_busy), 32'd0);
    chk("hs D src_ready", 32'(bus.src_ready), 32'b100);
    @(negedge clk);
    drive(2'd1, 3'b000, 1'b0); #1;
    chk("hs E out_valid", 32'(bus.out_valid), 32'd1);
    chk("hs E out_a", 32'(bus.out_a), 32'h77);
    chk("hs E out_src", 32'(bus.out_src), 32'd2);
    @(negedge clk);
    #1;
    chk("hs F busy", 32'(switch_busy), 32'd1);
    chk("hs F out_valid", 32'(bus.out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst mode_cur", 32'(mode_cur), 32'd0);
    chk("async rst busy", 32'(switch_busy), 32'd0);
    chk("async rst out_a", 32'(bus.out_a), 32'd0);
    @(negedge clk);
    drive(2'd0, 3'b000, 1'b1);
    reset = 1'b0;

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        va[i] = 8'($urandom); vb[i] = 8'($urandom); vo[i] = 3'($urandom);
      end
      if ($urandom_range(0, 7) == 0) mode_req = 2'($urandom_range(0, 3));
      drive(mode_req, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      #1;
      model_check($sformatf("rnd%0d", c));
      model_edge();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/op_source_mux.md
Name: op_source_mux

Overview:
Parametrised successor to the two-way manual/ROM operand switch. It selects one of NUM_SRC operand sources (a, b, opcode) for the ALU datapath through valid/ready handshakes and holds the selected word in a one-entry output register. A mode change never tears a transaction: the block drains the output register first, then retargets. Source 0 is manual/external control and source 1 is internal ROM execution; higher indices are additional masters.

Parameters:
DATA_W, 8, width of operands a and b
OP_W, 3, opcode width
NUM_SRC, 2, number of operand sources (>=2)
SEL_W, $clog2(NUM_SRC), source index width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mode_req  input  SEL_W  requested source index
src_valid  input  NUM_SRC  per-source word valid
src_ready  output  NUM_SRC  per-source accept
src_a  input  NUM_SRC*DATA_W  packed operand a, source i at [i*DATA_W +: DATA_W]
src_b  input  NUM_SRC*DATA_W  packed operand b, same packing
src_opcode  input  NUM_SRC*OP_W  packed opcodes
out_valid  output  1  output register holds a word
out_ready  input  1  downstream accepts
out_a  output  DATA_W  selected operand a
out_b  output  DATA_W  selected operand b
out_opcode  output  OP_W  selected opcode
out_src  output  SEL_W  source index of the held word
mode_cur  output  SEL_W  currently active source
switch_busy  output  1  high while a mode change is in progress

Behaviour:
- Reset values: state=RUN, mode_cur=0, out_valid=0, out_a/out_b/out_opcode/out_src=0, switch_busy=0. Reset is asynchronous. A held word is discarded on reset, mid-transfer or not.
- States: RUN, DRAIN, SWITCH. switch_busy = (state != RUN).
- Output register is free when out_valid=0 or out_ready=1 in the same cycle.
- src_ready[i] = (state==RUN) && (i==mode_cur) && free. All other bits are 0.
- Transfer occurs when src_valid[i] && src_ready[i]. On the next edge: out_* <= src_i fields, out_src <= i, out_valid <= 1.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1 word/cycle with out_ready held high.
- When out_valid && out_ready and no new transfer: out_valid <= 0. Data fields hold their last value.
- RUN->DRAIN: mode_req != mode_cur and mode_req < NUM_SRC. The target is latched in this cycle. A transfer in this same cycle still completes.
- mode_req >= NUM_SRC is ignored; state stays RUN.
- DRAIN: no source accepted. Go to SWITCH once the output register is empty or is being emptied this cycle (out_valid=0, or out_valid && out_ready).
- SWITCH: one cycle. mode_cur <= latched target, then RUN.
- mode_req changes during DRAIN or SWITCH are ignored. They are re-evaluated on the first RUN cycle.
- A request equal to mode_cur causes no state change.
- Minimum switch penalty with an empty register: 2 cycles of src_ready=0.
- Inactive sources' src_valid is ignored; no word is ever dropped or duplicated.

Decomposition:
- Shared package op_mux_pkg: state enum (RUN, DRAIN, SWITCH); constants MODE_MANUAL=0, MODE_ROM=1; default DATA_W and OP_W.
- One sub-module, op_out_reg: one-entry valid/ready pipeline register, parametrised on payload width.
- The FSM and the source mux stay in the top level.

Test Plan:
- Reset, then src_valid[0]=1 with a=0x12, b=0x34, op=3 and out_ready=1 -> src_ready[0]=1; next cycle out_valid=1, out_a=0x12, out_b=0x34, out_opcode=3, out_src=0.
- Back-to-back stream of 4 words from source 0 with out_ready=1 -> 4 consecutive out_valid cycles, data in order, no bubbles.
- Backpressure: out_ready=0 while out_valid=1 -> src_ready=0, out_* stable; raise out_ready -> the next word is accepted in the same cycle.
- Switch with a held word: out_valid=1, out_ready=0, mode_req 0->1 -> switch_busy=1 and src_ready=0 until out_ready=1; then one SWITCH cycle; then mode_cur=1 and src_ready[1]=1. Source 1 word 0xAA is delivered with out_src=1.
- Illegal request with NUM_SRC=3: mode_req=3 -> state stays RUN, mode_cur unchanged. Toggle mode_req during DRAIN -> only the first latched target takes effect.
- Asynchronous reset asserted mid-DRAIN while out_valid=1 -> immediately out_valid=0, mode_cur=0, switch_busy=0.
